// File: rtl/fpadd_sched.sv
// Round-robin scheduler sharing one multi-cycle fpadd among 2**ID_W requesters.
// Optional watchdog on the adder's done: define FPADD_SCHED_TIMEOUT_EN.
module fpadd_sched #(
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [(1<<ID_W)-1:0]      req_valid,
    input  logic [(1<<ID_W)*32-1:0]   req_a,
    input  logic [(1<<ID_W)*32-1:0]   req_b,
    output logic [(1<<ID_W)-1:0]      req_ready,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [31:0]               rsp_sum,
    output logic                      rsp_err,
    input  logic                      rsp_ready,
    output logic                      fa_start,
    output logic [31:0]               fa_a,
    output logic [31:0]               fa_b,
    input  logic [31:0]               fa_sum,
    input  logic                      fa_done
);

    localparam int NREQ = 1 << ID_W;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   ptr_reg;
    logic [31:0]       fa_a_reg, fa_b_reg;
    logic [ID_W-1:0]   rsp_id_reg;
    logic [31:0]       rsp_sum_reg;
    logic              rsp_err_reg;

    logic [31:0]       op_a [NREQ];
    logic [31:0]       op_b [NREQ];
    logic [NREQ-1:0]   rot_valid;
    logic [NREQ-1:0]   grant_onehot;
    logic [ID_W-1:0]   grant_id;
    logic              grant_found;
    logic              accept;
    logic              timeout_hit;

    // rot_valid[k] is the request k places after the priority pointer
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            logic [ID_W-1:0] rot_idx;
            assign op_a[gi]         = req_a[gi*32 +: 32];
            assign op_b[gi]         = req_b[gi*32 +: 32];
            assign rot_idx          = ptr_reg + ID_W'(gi);
            assign rot_valid[gi]    = req_valid[rot_idx];
            assign grant_onehot[gi] = grant_found && (grant_id == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        grant_found = 1'b0;
        grant_id    = ptr_reg;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                grant_found = 1'b1;
                grant_id    = ptr_reg + ID_W'(k);
            end
        end
    end

    assign req_ready = (state_reg == S_IDLE && !reset) ? grant_onehot : '0;
    assign accept    = |(req_valid & req_ready);

`ifdef FPADD_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    logic [CNT_W-1:0] wait_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == S_ISSUE) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == S_WAIT) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end

    assign timeout_hit = (wait_cnt_reg == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; fa_done is only meaningful in WAIT since the adder
    // keeps done high from the previous operation until it sees start.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (fa_done || timeout_hit) state_next = S_RESP;
            S_RESP:  if (rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        fa_start  = (state_reg == S_ISSUE);
        rsp_valid = (state_reg == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg     <= '0;
            fa_a_reg    <= '0;
            fa_b_reg    <= '0;
            rsp_id_reg  <= '0;
            rsp_sum_reg <= '0;
            rsp_err_reg <= 1'b0;
        end else begin
            if (accept) begin
                fa_a_reg   <= op_a[grant_id];
                fa_b_reg   <= op_b[grant_id];
                rsp_id_reg <= grant_id;
            end
            if (state_reg == S_WAIT) begin
                if (fa_done) begin
                    rsp_sum_reg <= fa_sum;
                    rsp_err_reg <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_sum_reg <= QNAN;
                    rsp_err_reg <= 1'b1;
                end
            end
            if (state_reg == S_RESP && rsp_ready) begin
                ptr_reg <= rsp_id_reg + 1'b1;
            end
        end
    end

    assign fa_a    = fa_a_reg;
    assign fa_b    = fa_b_reg;
    assign rsp_id  = rsp_id_reg;
    assign rsp_sum = rsp_sum_reg;
    assign rsp_err = rsp_err_reg;

endmodule

// File: tb/tb_fpadd_sched.sv
// Directed bench for fpadd_sched with a behavioural multi-cycle adder stand-in.
module tb_fpadd_sched;

    localparam int ID_W    = 2;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;
    localparam int LAT     = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*32-1:0] req_a, req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [ID_W-1:0]   rsp_id;
    logic [31:0]       rsp_sum;
    logic              rsp_err;
    logic              rsp_ready;
    logic              fa_start;
    logic [31:0]       fa_a, fa_b, fa_sum;
    logic              fa_done;

    int tests = 0;
    int fails = 0;

    fpadd_sched #(.ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready),
        .fa_start(fa_start), .fa_a(fa_a), .fa_b(fa_b), .fa_sum(fa_sum), .fa_done(fa_done)
    );

    always #5 clk = ~clk;

    // Adder stand-in: done rises LAT edges after the start edge, held until next start,
    // not cleared by the scheduler's reset. hang keeps it silent; force_done fakes a stale done.
    logic [31:0] m_a = '0, m_b = '0, m_sum = '0;
    int          m_cnt = 0;
    logic        m_done_reg = 1'b0;
    logic        hang = 1'b0;
    logic        force_done = 1'b0;
    int          start_cnt = 0;

    function automatic logic [31:0] fp_table(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h40400000;
            {32'h3F800000, 32'h3F800000}: return 32'h40000000;
            {32'h40000000, 32'h40000000}: return 32'h40800000;
            {32'h40400000, 32'h3F800000}: return 32'h40800000;
            {32'hBF800000, 32'h3F800000}: return 32'h00000000;
            {32'h40A00000, 32'hC0400000}: return 32'h40000000;
            default:                      return 32'hFFFFFFFF;
        endcase
    endfunction

    always @(posedge clk) begin
        if (fa_start) begin
            m_done_reg <= 1'b0;
            m_cnt      <= hang ? 0 : LAT;
            m_a        <= fa_a;
            m_b        <= fa_b;
            start_cnt  <= start_cnt + 1;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_done_reg <= 1'b1;
                m_sum      <= fp_table(m_a, m_b);
            end
        end
    end

    assign fa_done = m_done_reg | force_done;
    assign fa_sum  = m_sum;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One full operation: request -> grant -> start -> response -> consume.
    // Normal latency from the start cycle to rsp_valid: LAT edges to done, one WAIT
    // cycle sampling it, then RESP => LAT+2 cycles.
    task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_sum, input logic exp_err,
                         input int exp_lat, input int hold);
        int n;
        int s0;
        logic [3:0] oh;
        oh = 4'b0001 << id;
        s0 = start_cnt;
        @(negedge clk);
        rsp_ready = (hold == 0);
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        #1;
        n = 0;
        while (req_ready == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("grant_onehot", 32'(req_ready), 32'(oh));
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        check("fa_start_pulse", 32'(fa_start), 32'd1);
        check("fa_a_operand", fa_a, a);
        check("fa_b_operand", fa_b, b);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 200);
        check("rsp_latency", n, exp_lat);
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), id);
        check("rsp_sum", rsp_sum, exp_sum);
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        if (hold > 0) begin
            req_valid = 4'hF;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
                check("bp_rsp_id", 32'(rsp_id), id);
                check("bp_rsp_sum", rsp_sum, exp_sum);
                check("bp_req_ready", 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            check("bp_release_valid", 32'(rsp_valid), 32'd0);
            check("bp_next_ptr_grant", 32'(req_ready), 32'(4'b0001 << ((id + 1) % NREQ)));
            req_valid = '0;
        end else begin
            @(negedge clk);
            check("rsp_drop", 32'(rsp_valid), 32'd0);
        end
        check("one_start_per_op", start_cnt - s0, 1);
        $display("[TB] op id=%0d a=%h b=%h -> id=%0d sum=%h err=%0d lat=%0d",
                 id, a, b, rsp_id, rsp_sum, rsp_err, n);
    endtask

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g[6];
        int got;
        int s0;
        int exp_order[6] = '{0, 1, 2, 3, 0, 1};

        vecs[0] = '{2, 32'h3F800000, 32'h40000000, 32'h40400000};
        vecs[1] = '{0, 32'h3F800000, 32'h3F800000, 32'h40000000};
        vecs[2] = '{1, 32'h40000000, 32'h40000000, 32'h40800000};
        vecs[3] = '{3, 32'h40400000, 32'h3F800000, 32'h40800000};
        vecs[4] = '{2, 32'hBF800000, 32'h3F800000, 32'h00000000};
        vecs[5] = '{1, 32'h40A00000, 32'hC0400000, 32'h40000000};

        // Reset with every requester asserting
        reset     = 1'b1;
        req_valid = 4'hF;
        req_a     = {4{32'h3F800000}};
        req_b     = {4{32'h3F800000}};
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_fa_start", 32'(fa_start), 32'd0);
        check("reset_fa_a", fa_a, 32'd0);
        check("reset_fa_b", fa_b, 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_rsp_sum", rsp_sum, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        $display("[TB] reset done");

        // Fairness: all four valid continuously from reset release
        s0 = start_cnt;
        reset = 1'b0;
        got = 0;
        for (int c = 0; c < 200 && got < 6; c++) begin
            #1;
            if (req_ready != '0) begin
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) g[got] = i;
                $display("[TB] fairness grant %0d -> id %0d", got, g[got]);
                got++;
                if (got == 6) begin
                    @(posedge clk);
                    #1 req_valid = '0;
                end
            end
            if (got < 6) @(negedge clk);
        end
        check("fair_grant_count", got, 6);
        for (int i = 0; i < 6; i++) check("fair_order", g[i], exp_order[i]);
        repeat (20) @(negedge clk);
        check("fair_start_count", start_cnt - s0, 6);
        check("fair_idle_after", 32'(rsp_valid), 32'd0);

        // Table of single operations
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum, 1'b0, LAT + 2, 0);
        end

        // Backpressure: response held 5 cycles
        do_op(0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, LAT + 2, 5);

`ifdef FPADD_SCHED_TIMEOUT_EN
        // Watchdog: ISSUE, then TIMEOUT WAIT cycles, then RESP
        hang = 1'b1;
        do_op(3, 32'h40000000, 32'h40000000, 32'h7FC00000, 1'b1, TIMEOUT + 1, 0);
        hang = 1'b0;
        do_op(3, 32'h40000000, 32'h40000000, 32'h40800000, 1'b0, LAT + 2, 0);
`endif

        // Reset while waiting with done asserted; leave ptr at 2 beforehand
        do_op(1, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, LAT + 2, 0);
        hang = 1'b1;
        @(negedge clk);
        req_valid = 4'b0010;
        req_a[63:32] = 32'h40400000;
        req_b[63:32] = 32'h3F800000;
        #1;
        check("rw_grant", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (3) @(negedge clk);
        force_done = 1'b1;
        reset      = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rw_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rw_fa_start", 32'(fa_start), 32'd0);
        check("rw_rsp_id", 32'(rsp_id), 32'd0);
        check("rw_fa_a", fa_a, 32'd0);
        got = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid) got++;
        end
        check("rw_no_stale_rsp", got, 0);
        force_done = 1'b0;
        hang       = 1'b0;
        req_valid  = 4'b1010;
        #1;
        check("rw_ptr_zero_grant", 32'(req_ready), 32'h2);
        req_valid = '0;
        $display("[TB] reset-in-wait done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fpadd_sched.md
# fpadd_sched

Round-robin scheduler that shares one multi-cycle `fpadd` single-precision adder among several requesters. It sits between the requester ports and the adder's `start`/`a`/`b`/`sum`/`done` interface. Each requester presents an operand pair with a valid/ready handshake. The block issues one operation at a time to the adder and returns the 32-bit result tagged with the requester ID. An optional watchdog aborts operations the adder never completes.

## Interface
- `ID_W`, default 2: requester ID width; `NREQ = 1 << ID_W` requesters.
- `TIMEOUT`, default 64: cycles allowed in WAIT before abort; used only with `FPADD_SCHED_TIMEOUT_EN`.
- `clk`  in  1: clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid`  in  NREQ: per-requester request valid.
- `req_a`  in  NREQ*32: operand A for requester i, at bits [32i+31:32i].
- `req_b`  in  NREQ*32: operand B for requester i, same packing as `req_a`.
- `req_ready`  out  NREQ: one-hot accept. A request transfers on `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  1: result valid.
- `rsp_id`  out  ID_W: requester that owns the result.
- `rsp_sum`  out  32: IEEE-754 single-precision result.
- `rsp_err`  out  1: operation aborted by the watchdog.
- `rsp_ready`  in  1: consumer accepts the result.
- `fa_start`  out  1: to adder `start`, a one-cycle pulse.
- `fa_a`, `fa_b`  out  32 each: to adder `a`/`b`, registered and held stable from accept until the next accept.
- `fa_sum`  in  32: from adder `sum`.
- `fa_done`  in  1: from adder `done`. The adder holds `done` high until its next start, and its reset does not clear `done`.

## Operation
- State machine has four states: IDLE, ISSUE, WAIT, RESP. Encoding is free.
- Round-robin pointer `ptr` (ID_W bits) holds the highest-priority ID.
- **IDLE**
  - Winner is the first `i` with `req_valid[i]` set, searching `ptr, ptr+1, …` modulo NREQ.
  - `req_ready` is combinational: one-hot of the winner, gated by `state==IDLE`. It is all-zero when no request is valid.
  - On transfer: latch `req_a`/`req_b` into `fa_a`/`fa_b`, latch the winner into `rsp_id`, then go to ISSUE.
- **ISSUE**: drive `fa_start=1` for exactly this cycle, then go to WAIT.
- **WAIT**
  - `fa_done` is sampled only in this state.
  - On `fa_done=1`: register `fa_sum` into `rsp_sum`, clear `rsp_err`, then go to RESP.
- **RESP**
  - `rsp_valid=1`. `rsp_sum`, `rsp_id` and `rsp_err` are held stable.
  - On `rsp_ready=1`: go to IDLE, set `ptr <= rsp_id + 1` (wraps modulo NREQ), and drop `rsp_valid` in the next cycle.
- `req_ready` is 0 in every state except IDLE, so there is no request queuing.
- A requester may drop `req_valid` before it is granted; arbitration is re-evaluated every IDLE cycle.

## Timing
- Reset values:
  - state IDLE, `ptr=0`
  - `fa_start=0`, `fa_a=fa_b=0`
  - `rsp_valid=0`, `rsp_id=0`, `rsp_sum=0`, `rsp_err=0`
  - `req_ready=0` in the reset cycle
- Reset mid-operation: the next cycle is IDLE with the reset values above. A stale `fa_done=1` from the adder is ignored. The aborted operation produces no response.
- Reset has priority over every simultaneous event.
- Latency:
  - Accept at edge 0; `fa_start` high in cycle 1; WAIT from cycle 2.
  - `rsp_valid` rises the cycle after `fa_done` is first sampled high in WAIT.
- Minimum occupancy is adder latency + 3 cycles per operation when `rsp_ready` is held at 1.
- `fa_done` seen in the ISSUE cycle comes from the previous operation and must not be used.

## Configuration
- `FPADD_SCHED_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments every WAIT cycle.
  - If the counter reaches `TIMEOUT-1` with `fa_done` still 0: go to RESP with `rsp_err=1` and `rsp_sum=32'h7FC00000`.
  - The next ISSUE restarts the adder.
- `FPADD_SCHED_TIMEOUT_EN` undefined:
  - No counter is built.
  - WAIT waits indefinitely.
  - `rsp_err` is tied to 0.

## Test plan
- **Reset**: hold `reset` for 3 cycles with all `req_valid=1` → `req_ready=0`, `rsp_valid=0`, `fa_start=0`, `fa_a=fa_b=0`, `rsp_*=0`.
- **Single request**: `req_valid[2]=1`, `a=32'h3F800000`, `b=32'h40000000` → `req_ready=4'b0100` for one cycle. `fa_start` pulses once with those operands. Response is `rsp_valid=1`, `rsp_id=2`, `rsp_sum=32'h40400000`, `rsp_err=0`.
- **Fairness**: all four requesters assert continuously after reset → grant order 0,1,2,3,0,1. Exactly one `fa_start` per grant.
- **Backpressure**: hold `rsp_ready=0` for 5 cycles in RESP → `rsp_valid`, `rsp_id` and `rsp_sum` stay constant, and `req_ready` stays 0. Release `rsp_ready` → back to IDLE in the next cycle.
- **Timeout** (`FPADD_SCHED_TIMEOUT_EN`, `TIMEOUT=8`): adder model holds `fa_done=0` → after 8 WAIT cycles, `rsp_err=1` and `rsp_sum=32'h7FC00000`. The next request then completes normally with `rsp_err=0`.
- **Reset in WAIT**: assert `reset` for 1 cycle while the model has `fa_done=1` → the next cycle is IDLE, with no `rsp_valid` and `ptr=0`. The stale `fa_done` never produces a response.
